// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline register chain.
// Boundary payload structs are packed into the chain's in_data bus.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifId_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  aluOp;
    } idEx_t;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  rd;
        logic        memRead;
        logic        memWrite;
    } exMem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regWrite;
    } memWb_t;

    // Width needed to count 0..stages valid slots.
    function automatic int occW(input int stages);
        return $clog2(stages + 1);
    endfunction

    // Adds b to a, clamping at 2^w-1 (w up to 64).
    function automatic logic [63:0] satAdd(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int          w);
        logic [64:0] sum;
        logic [63:0] maxVal;
        maxVal = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum    = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, maxVal})
            return maxVal;
        return sum[63:0];
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the chain: flush beats load, load beats drain, else hold.
// The data register is only written on reset, flush or load.
module pipe_slot #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic             flush,
    input  logic [WIDTH-1:0] loadData,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset || flush)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (advance)
            valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush)
            data <= RESET_DATA;
        else if (load)
            data <= loadData;
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with per-slot flush, bubble collapse,
// occupancy report and a saturating count of flushed items.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               STAGES     = 4,
    parameter int               CNT_W      = 16,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [STAGES-1:0]           flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [STAGES-1:0]           stage_valid,
    output logic [occW(STAGES)-1:0]     occupancy,
    output logic [CNT_W-1:0]            flush_count
);

    localparam int OCC_W = occW(STAGES);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] discard;
    logic [WIDTH-1:0]  d        [STAGES];
    logic [WIDTH-1:0]  loadData [STAGES];
    logic              accept;
    logic [OCC_W-1:0]  discCnt;
    logic [CNT_W-1:0]  flushCnt;

    // A slot advances when the consumer takes it, or when any slot below it is
    // empty: the empty slot pulls, which collapses bubbles under back-pressure.
    always_comb begin
        logic downFull;
        adv      = '0;
        downFull = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i]   = v[i] & (out_ready | ~downFull);
            downFull = downFull & v[i];
        end
    end

    assign in_ready = ~v[0] | adv[0];
    assign accept   = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gSlot
            if (gi == 0) begin : gEntry
                assign load[gi]     = accept;
                assign loadData[gi] = in_data;
            end else begin : gInner
                assign load[gi]     = adv[gi-1];
                assign loadData[gi] = d[gi-1];
            end

            // Lost item: something that would occupy this slot next cycle.
            assign discard[gi] = flush[gi] & (load[gi] | (v[gi] & ~adv[gi]));

            pipe_slot #(
                .WIDTH      (WIDTH),
                .RESET_DATA (RESET_DATA)
            ) uSlot (
                .clk      (clk),
                .reset    (reset),
                .load     (load[gi]),
                .advance  (adv[gi]),
                .flush    (flush[gi]),
                .loadData (loadData[gi]),
                .valid    (v[gi]),
                .data     (d[gi])
            );
        end
    endgenerate

    always_comb begin
        occupancy = '0;
        discCnt   = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
            discCnt   = discCnt + OCC_W'(discard[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            flushCnt <= '0;
        else
            flushCnt <= CNT_W'(satAdd(64'(flushCnt), 64'(discCnt), CNT_W));
    end

    assign out_valid   = v[STAGES-1];
    assign out_data    = d[STAGES-1];
    assign stage_valid = v;
    assign flush_count = flushCnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed-vector bench for pipe_stage_chain (4 slots, 2-bit flush counter,
// non-zero reset payload so flushed/reset data is distinguishable).
module tb_pipe_stage_chain;

    localparam int          W  = 16;
    localparam int          S  = 4;
    localparam int          CW = 2;
    localparam logic [15:0] RD = 16'h5A5A;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  inData;
    logic [S-1:0]  flush;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  outData;
    logic [S-1:0]  stageValid;
    logic [2:0]    occupancy;
    logic [CW-1:0] flushCount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_chain #(
        .WIDTH      (W),
        .STAGES     (S),
        .CNT_W      (CW),
        .RESET_DATA (RD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .in_data     (inData),
        .flush       (flush),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_data    (outData),
        .stage_valid (stageValid),
        .occupancy   (occupancy),
        .flush_count (flushCount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1; inValid = 1'b0; outReady = 1'b0; flush = '0; inData = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic fill4(input logic [W-1:0] base);
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inValid = 1'b1;
            inData  = base + W'(i);
            step();
        end
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inValid = 1'b1; inData = 16'h1234; outReady = 1'b1; flush = '1;
        step();
        reset = 1'b0; inValid = 1'b0; outReady = 1'b0; flush = '0;
        #1;
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", outValid); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", inReady); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (stageValid !== 4'b0000) begin failures++; $display("FAIL reset_stage_valid got=%b exp=0000", stageValid); end
        checks++; if (flushCount !== 2'd0) begin failures++; $display("FAIL reset_flush_count got=%0d exp=0", flushCount); end
        checks++; if (outData !== RD) begin failures++; $display("FAIL reset_out_data got=%h exp=%h", outData, RD); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        logic          expValid;
        logic [W-1:0]  expData;
        doReset();
        outReady = 1'b1;
        for (int c = 0; c < 12; c++) begin
            inValid = (c < 8);
            inData  = W'(c + 1);
            #1;
            if (c < 8) begin
                checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%0h exp=1", c, inReady); end
            end
            step();
            expValid = (c >= 3) && (c <= 10);
            expData  = W'(c - 2);
            checks++; if (outValid !== expValid) begin failures++; $display("FAIL stream_out_valid cyc=%0d got=%0h exp=%0h", c, outValid, expValid); end
            if (expValid) begin
                checks++; if (outData !== expData) begin failures++; $display("FAIL stream_out_data cyc=%0d got=%h exp=%h", c, outData, expData); end
            end
            if (c >= 3 && c <= 7) begin
                checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL stream_occupancy cyc=%0d got=%0d exp=4", c, occupancy); end
            end
        end
        inValid = 1'b0;
        $display("test_stream done");
    endtask

    task automatic test_full();
        doReset();
        fill4(16'h00A1);
        inValid = 1'b1; inData = 16'h00FF;
        #1;
        checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0h exp=0", inReady); end
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_occupancy got=%0d exp=4", occupancy); end
        checks++; if (outData !== 16'h00A1) begin failures++; $display("FAIL full_hold_data got=%h exp=00a1", outData); end
        inValid = 1'b0; outReady = 1'b1;
        #1;
        checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL full_release_in_ready got=%0h exp=1", inReady); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL drain_out_valid idx=%0d got=%0h exp=1", j, outValid); end
            checks++; if (outData !== 16'h00A1 + W'(j)) begin failures++; $display("FAIL drain_out_data idx=%0d got=%h exp=%h", j, outData, 16'h00A1 + W'(j)); end
            step();
        end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL drain_occupancy got=%0d exp=0", occupancy); end
        outReady = 1'b0;
        $display("test_full done");
    endtask

    task automatic test_bubble();
        doReset();
        inValid = 1'b1; inData = 16'h00B1;
        step();
        inValid = 1'b0;
        step(); step(); step();
        checks++; if (stageValid !== 4'b1000) begin failures++; $display("FAIL bubble_setup1 got=%b exp=1000", stageValid); end
        inValid = 1'b1; inData = 16'h00B2;
        step();
        inValid = 1'b0;
        checks++; if (stageValid !== 4'b1001) begin failures++; $display("FAIL bubble_setup2 got=%b exp=1001", stageValid); end
        step();
        checks++; if (stageValid !== 4'b1010) begin failures++; $display("FAIL bubble_collapse got=%b exp=1010", stageValid); end
        checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL bubble_occupancy got=%0d exp=2", occupancy); end
        checks++; if (outData !== 16'h00B1) begin failures++; $display("FAIL bubble_out_data got=%h exp=00b1", outData); end
        $display("test_bubble done");
    endtask

    task automatic test_flush();
        doReset();
        fill4(16'h00C1);
        inValid = 1'b1; inData = 16'h00C9; flush = 4'b0011;
        #1;
        checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL flush_in_ready_full got=%0h exp=0", inReady); end
        step();
        flush = '0; inValid = 1'b0;
        checks++; if (stageValid !== 4'b1100) begin failures++; $display("FAIL flush_stage_valid got=%b exp=1100", stageValid); end
        checks++; if (flushCount !== 2'd2) begin failures++; $display("FAIL flush_count_two got=%0d exp=2", flushCount); end
        inValid = 1'b1; inData = 16'h00CA; flush = 4'b0001;
        #1;
        checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL flush_in_ready_flushed got=%0h exp=1", inReady); end
        step();
        flush = '0; inValid = 1'b0;
        checks++; if (stageValid !== 4'b1100) begin failures++; $display("FAIL flush_accept_discard got=%b exp=1100", stageValid); end
        checks++; if (flushCount !== 2'd3) begin failures++; $display("FAIL flush_count_input got=%0d exp=3", flushCount); end
        checks++; if (outData !== 16'h00C1) begin failures++; $display("FAIL flush_out_data got=%h exp=00c1", outData); end
        $display("test_flush done");
    endtask

    task automatic test_flush_out();
        doReset();
        inValid = 1'b1; inData = 16'h00D1;
        step();
        inValid = 1'b0;
        step(); step(); step();
        outReady = 1'b1; flush = 4'b1000;
        #1;
        checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL flushout_valid got=%0h exp=1", outValid); end
        checks++; if (outData !== 16'h00D1) begin failures++; $display("FAIL flushout_data got=%h exp=00d1", outData); end
        step();
        flush = '0; outReady = 1'b0;
        checks++; if (flushCount !== 2'd0) begin failures++; $display("FAIL flushout_delivered_count got=%0d exp=0", flushCount); end
        checks++; if (stageValid !== 4'b0000) begin failures++; $display("FAIL flushout_delivered_sv got=%b exp=0000", stageValid); end
        inValid = 1'b1; inData = 16'h00D2;
        step();
        inValid = 1'b0;
        step(); step(); step();
        flush = 4'b1000;
        step();
        flush = '0;
        checks++; if (flushCount !== 2'd1) begin failures++; $display("FAIL flushout_dropped_count got=%0d exp=1", flushCount); end
        checks++; if (stageValid !== 4'b0000) begin failures++; $display("FAIL flushout_dropped_sv got=%b exp=0000", stageValid); end
        checks++; if (outData !== RD) begin failures++; $display("FAIL flushout_reset_data got=%h exp=%h", outData, RD); end
        $display("test_flush_out done");
    endtask

    task automatic test_saturate();
        doReset();
        fill4(16'h00E1);
        flush = 4'b1111; inValid = 1'b1; inData = 16'h00E8;
        step();
        flush = '0; inValid = 1'b0;
        checks++; if (flushCount !== 2'd3) begin failures++; $display("FAIL sat_count_four got=%0d exp=3", flushCount); end
        checks++; if (stageValid !== 4'b0000) begin failures++; $display("FAIL sat_stage_valid got=%b exp=0000", stageValid); end
        inValid = 1'b1; inData = 16'h00E9; flush = 4'b0001;
        step();
        flush = '0; inValid = 1'b0;
        checks++; if (flushCount !== 2'd3) begin failures++; $display("FAIL sat_count_hold got=%0d exp=3", flushCount); end
        $display("test_saturate done");
    endtask

    task automatic test_reset_mid();
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1; inData = 16'h00F1 + W'(i);
            step();
        end
        reset = 1'b1; flush = 4'b0010;
        step();
        reset = 1'b0; inValid = 1'b0; outReady = 1'b0; flush = '0;
        #1;
        checks++; if (stageValid !== 4'b0000) begin failures++; $display("FAIL midreset_stage_valid got=%b exp=0000", stageValid); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL midreset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%0h exp=1", inReady); end
        checks++; if (flushCount !== 2'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", flushCount); end
        checks++; if (outData !== RD) begin failures++; $display("FAIL midreset_out_data got=%h exp=%h", outData, RD); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b0; inValid = 1'b0; outReady = 1'b0; flush = '0; inData = '0;
        test_reset();
        test_stream();
        test_full();
        test_bubble();
        test_flush();
        test_flush_out();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
